serial_add_arbiter: RTL and testbench
=====================================

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant: NIB = WIDTH/4, the number of nibble steps per operation.
REQ-003 Port: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Ports: req0_valid  input  1, req0_ready  output  1, req0_a  input  WIDTH, req0_b  input  WIDTH, req0_cin  input  1; requester 0 add request.
REQ-006 Ports: req1_valid, req1_ready, req1_a, req1_b, req1_cin, with the same directions and widths as requester 0; requester 1 add request.
REQ-007 Ports: res_valid  output  1, res_ready  input  1, res_sum  output  WIDTH, res_cout  output  1, res_id  output  1; result channel, where res_id is the requester index.

Function
REQ-008 The block SHALL compute {res_cout, res_sum} = a + b + cin using exactly one 4-bit full-adder datapath, reused over NIB cycles (nibble-serial, LSB nibble first).
REQ-009 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-010 In IDLE, reqN_ready SHALL be 1 only for the granted requester, and SHALL be 0 in CALC and DONE.
REQ-011 Grant in IDLE: if only one valid is high, that requester is granted; if both are high, the requester not granted last is granted (round-robin); if neither is high, both readys SHALL be 0.
REQ-012 Acceptance SHALL occur on the clock edge where reqN_valid and reqN_ready are both 1.
REQ-013 On acceptance, the block SHALL latch a, b, cin and the requester index, set the last-grant pointer to N, clear the nibble index, and move to CALC.
REQ-014 Operand changes after acceptance SHALL NOT affect the result.
REQ-015 CALC step k (k = 0..NIB-1): nibble k of a and b plus the carry register SHALL be added; the 4-bit sum SHALL be written to sum bits [4k+3:4k] and the carry register updated; the carry-in for k = 0 SHALL be the latched cin.
REQ-016 After step NIB-1, the FSM SHALL move to DONE, with res_cout equal to the final carry.
REQ-017 Latency: when acceptance occurs at edge T, res_valid SHALL be 1 from edge T+NIB onward.
REQ-018 In DONE, res_valid SHALL be 1, and res_sum, res_cout and res_id SHALL be stable until res_valid and res_ready are both 1 on a clock edge; the FSM SHALL then return to IDLE.
REQ-019 res_valid SHALL be 0 in IDLE and CALC.
REQ-020 No new request SHALL be accepted on the same edge as result consumption.
REQ-021 Minimum issue interval: NIB+2 cycles.
REQ-022 A requester that deasserts valid before acceptance SHALL lose its pending grant, with no side effects.
REQ-023 Back-pressure: if res_ready is held at 0 indefinitely, the block SHALL hold DONE and keep both readys at 0.
REQ-024 Wrap-around: a carry out of bit WIDTH-1 SHALL appear only on res_cout, and res_sum SHALL be the sum modulo 2^WIDTH.
REQ-025 When WIDTH = 4, CALC SHALL last exactly one cycle.

Reset
REQ-026 While rst_n = 0, the block SHALL immediately force: state IDLE, res_valid 0, req0_ready 0, req1_ready 0, res_sum 0, res_cout 0, res_id 0, carry 0, nibble index 0, and last-grant pointer 1 (so requester 0 wins the first contention).
REQ-027 Reset asserted in CALC or DONE SHALL abandon the operation, and no result SHALL be emitted after release.
REQ-028 After rst_n rises, the first acceptance SHALL be possible on the first subsequent rising edge.

Verification (WIDTH = 16)
REQ-029 Single request: req0 with a=0x1234, b=0x0F0F, cin=0 is accepted at edge T -> res_valid rises at T+4 with res_sum=0x2143, res_cout=0, res_id=0.
REQ-030 Full carry ripple: req1 with a=0xFFFF, b=0x0000, cin=1 -> res_sum=0x0000, res_cout=1, res_id=1.
REQ-031 Contention: both valid after reset -> req0 is served first, then req1 (held valid) is granted next; repeated contention alternates 0,1,0,1.
REQ-032 Back-pressure: res_ready=0 for 10 cycles in DONE -> outputs stable, both readys 0; res_ready=1 -> one consumption, IDLE on the next edge.
REQ-033 Mid-operation reset: rst_n pulsed low during CALC step 2 -> all outputs are 0 immediately, and no res_valid occurs after release without a new request.
REQ-034 Operand isolation: req0_a changed from 0x0001 to 0xFFFF one cycle after acceptance, with b=0x0001 and cin=0 -> res_sum=0x0002.

Source files
------------

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two-requester round-robin front end for a nibble-serial adder
// that reuses one 4-bit full adder over WIDTH/4 cycles.
module serial_add_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);
    localparam int NIB = WIDTH / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, id_q, id_d, last_q, last_d;
    logic [NW-1:0]    nib_q, nib_d;
    logic             g0, g1;
    logic [4:0]       add;

    always_comb begin
        g0         = req0_valid && (!req1_valid || last_q);
        g1         = req1_valid && (!req0_valid || !last_q);
        req0_ready = rst_n && (state_q == IDLE) && g0;
        req1_ready = rst_n && (state_q == IDLE) && g1;
        add        = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        id_d       = id_q;
        last_d     = last_q;
        nib_d      = nib_q;
        case (state_q)
            IDLE: if (g0 || g1) begin
                a_d     = g1 ? req1_a : req0_a;
                b_d     = g1 ? req1_b : req0_b;
                carry_d = g1 ? req1_cin : req0_cin;
                id_d    = g1;
                last_d  = g1;
                nib_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                // operands shift down so the adder always sees nibble 0; sums enter at the top
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                sum_d   = (sum_q >> 4) | (WIDTH'(add[3:0]) << (WIDTH - 4));
                carry_d = add[4];
                nib_d   = nib_q + NW'(1);
                if (nib_q == NW'(NIB - 1)) begin
                    cout_d  = add[4];
                    state_d = DONE;
                end
            end
            DONE: state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            nib_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            last_q  <= last_d;
            nib_q   <= nib_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// tb_serial_add_arbiter: randomized and directed checks of the serial adder/arbiter
// against a round-robin plus a+b+cin reference model.
module tb_serial_add_arbiter;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_cout, res_id;
    logic [W-1:0] res_sum;

    int checks = 0;
    int errors = 0;
    bit mlast;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; the model picks the winner and computes the expected sum.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input bit c0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input bit c1,
                          input bit hold, input int stall, input string name);
        bit         id;
        logic [W:0] exp;
        logic [1:0] rdy;
        id  = (v0 && v1) ? !mlast : v1;
        exp = id ? ({1'b0, a1} + {1'b0, b1} + (W+1)'(c1)) : ({1'b0, a0} + {1'b0, b0} + (W+1)'(c0));
        rdy = id ? 2'b10 : 2'b01;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== rdy) begin
            errors++;
            $display("FAIL %s grant: ready=%b expected %b", name, {req1_ready, req0_ready}, rdy);
        end
        tick;
        mlast = id;
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
        for (int i = 0; i < NIB; i++) begin
            checks++;
            if (res_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s calc cycle %0d: valid=%b readys=%b expected 0 00", name, i, res_valid, {req1_ready, req0_ready});
            end
            tick;
        end
        checks++;
        if (res_valid !== 1'b1 || {res_cout, res_sum} !== exp || res_id !== id) begin
            errors++;
            $display("FAIL %s result: valid=%b cout_sum=%h id=%b expected 1 %h %b", name, res_valid, {res_cout, res_sum}, res_id, exp, id);
        end
        if (stall > 0) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            tick;
            checks++;
            if (res_valid !== 1'b1 || {res_cout, res_sum} !== exp || res_id !== id || {req1_ready, req0_ready} !== 2'b00) begin
                errors++;
                $display("FAIL %s stall %0d: valid=%b cout_sum=%h id=%b readys=%b expected 1 %h %b 00", name, s, res_valid, {res_cout, res_sum}, res_id, {req1_ready, req0_ready}, exp, id);
            end
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s consume: valid=%b expected 0", name, res_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        #3;
        checks++;
        if ({res_valid, req0_ready, req1_ready, res_sum, res_cout, res_id} !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b readys=%b sum=%h cout=%b id=%b expected all 0", res_valid, {req1_ready, req0_ready}, res_sum, res_cout, res_id);
        end
        tick;
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        mlast = 1'b1;
    endtask

    task automatic test_single;
        run_op(1, 0, 16'h1234, 16'h0F0F, 0, 16'h0, 16'h0, 0, 0, 0, "single");
    endtask

    task automatic test_carry;
        run_op(0, 1, 16'h0, 16'h0, 0, 16'hFFFF, 16'h0000, 1, 0, 0, "ripple");
    endtask

    task automatic test_contention;
        test_reset;
        for (int i = 0; i < 4; i++)
            run_op(1, 1, W'($urandom), W'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1, 0, "contention");
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        run_op(1, 0, W'($urandom), W'($urandom), 1'($urandom), 16'h0, 16'h0, 0, 0, 10, "backpressure");
    endtask

    task automatic test_mid_reset;
        req0_valid = 1'b1; req0_a = 16'hABCD; req0_b = 16'h1111; req0_cin = 1'b1;
        tick;
        req0_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({res_valid, req0_ready, req1_ready, res_sum, res_cout, res_id} !== '0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b readys=%b sum=%h cout=%b id=%b expected all 0", res_valid, {req1_ready, req0_ready}, res_sum, res_cout, res_id);
        end
        tick;
        #2;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        mlast = 1'b1;
        for (int i = 0; i < NIB + 3; i++) begin
            tick;
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset release %0d: valid=%b expected 0", i, res_valid);
            end
        end
    endtask

    task automatic test_isolation;
        run_op(1, 0, 16'h0001, 16'h0001, 0, 16'h0, 16'h0, 0, 0, 0, "isolation");
    endtask

    task automatic test_withdraw;
        req0_valid = 1'b1;
        #2;
        req0_valid = 1'b0;
        for (int i = 0; i < NIB + 2; i++) begin
            tick;
            checks++;
            if (res_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
                errors++;
                $display("FAIL withdraw %0d: valid=%b readys=%b expected 0 00", i, res_valid, {req1_ready, req0_ready});
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            run_op(v0, v1, W'($urandom), W'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   0, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        test_reset;
        test_single;
        test_carry;
        test_contention;
        test_backpressure;
        test_mid_reset;
        test_single;
        test_isolation;
        test_withdraw;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
